// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART serial port.
package spart_pkg;

  // Register map seen by the driver
  localparam logic [1:0] ADDR_RX  = 2'b00;
  localparam logic [1:0] ADDR_TX  = 2'b01;
  localparam logic [1:0] ADDR_DBL = 2'b10;
  localparam logic [1:0] ADDR_DBH = 2'b11;

  // Divisor loaded at reset
  localparam logic [15:0] DEFAULT_DIVISOR = 16'h0145;

  // Ticks per bit at 16x oversampling; the receiver samples mid-bit
  localparam logic [3:0] TICKS_LAST = 4'd15;
  localparam logic [3:0] TICKS_HALF = 4'd7;

  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'b00,
    RX_START = 2'b01,
    RX_DATA  = 2'b10,
    RX_STOP  = 2'b11
  } rx_state_t;

  // One decoded bus cycle from the driver
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_req_t;

  // Status register layout
  function automatic logic [7:0] status_byte(input logic tbr, input logic rda);
    return {6'b0, tbr, rda};
  endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Baud generator: down-counter producing one 16x oversample tick per period.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = DEFAULT_DIVISOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic        reload,
  output logic        tick
);

  logic [15:0] cnt;

  // A reload restarts the period with the new divisor; zero wraps back to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= RESET_VAL;
    else if (reload || cnt == '0)  cnt <= divisor;
    else                           cnt <= cnt - 16'd1;
  end

  // Period is divisor+1 clocks; the tick lasts exactly the zero cycle.
  assign tick = (cnt == '0);

endmodule

// File: rtl/spart.sv
// SPART: byte-wide driver interface to an 8N1 serial transmitter/receiver.
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] RESET_DIVISOR = DEFAULT_DIVISOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  bus_req_t    req;
  logic [15:0] divisor;
  logic        div_reload;
  logic        tick;

  tx_state_t   tx_state;
  logic [9:0]  tx_sr;
  logic [3:0]  tx_tcnt;
  logic [3:0]  tx_bcnt;

  logic        rx_meta, rx_sync, rx_prev;
  rx_state_t   rx_state;
  logic [3:0]  rx_tcnt;
  logic [2:0]  rx_bcnt;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_buf;
  logic        rx_load;
  logic [7:0]  rd_data;

  assign req = '{wr: iocs & ~iorw, rd: iocs & iorw, addr: ioaddr, data: databus};

  // ---------------- divisor and baud tick ----------------

  // Divisor bytes are written independently; either write restarts the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor    <= RESET_DIVISOR;
      div_reload <= 1'b0;
    end else begin
      div_reload <= req.wr && req.addr[1];
      if (req.wr && req.addr == ADDR_DBL) divisor[7:0]  <= req.data;
      if (req.wr && req.addr == ADDR_DBH) divisor[15:8] <= req.data;
    end
  end

  spart_baud_gen #(.RESET_VAL(RESET_DIVISOR)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .divisor (divisor),
    .reload  (div_reload),
    .tick    (tick)
  );

  // ---------------- transmitter ----------------

  // Load a full frame on a TX write while idle, then shift one bit per 16 ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_sr    <= '1;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (req.wr && req.addr == ADDR_TX) begin
            tx_sr    <= {1'b1, req.data, 1'b0};
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_state <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tick) begin
            if (tx_tcnt == TICKS_LAST) begin
              tx_tcnt <= '0;
              tx_sr   <= {1'b1, tx_sr[9:1]};
              if (tx_bcnt == 4'd9) begin
                tx_bcnt  <= '0;
                tx_state <= TX_IDLE;
              end else begin
                tx_bcnt <= tx_bcnt + 4'd1;
              end
            end else begin
              tx_tcnt <= tx_tcnt + 4'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Writes while busy fall through the idle-only load above and are dropped.
  assign tbr = (tx_state == TX_IDLE);
  assign txd = (tx_state == TX_SHIFT) ? tx_sr[0] : 1'b1;

  // ---------------- receiver ----------------

  // Two-flop synchronizer plus a delayed copy for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Start bit checked mid-bit, then data and stop bits sampled every 16 ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_sr    <= '0;
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_tcnt  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tcnt == TICKS_HALF) begin
              rx_tcnt  <= '0;
              rx_bcnt  <= '0;
              rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              rx_tcnt <= rx_tcnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_tcnt == TICKS_LAST) begin
              rx_tcnt <= '0;
              rx_sr   <= {rx_sync, rx_sr[7:1]};
              if (rx_bcnt == 3'd7) rx_state <= RX_STOP;
              else                 rx_bcnt  <= rx_bcnt + 3'd1;
            end else begin
              rx_tcnt <= rx_tcnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_tcnt == TICKS_LAST) begin
              rx_tcnt  <= '0;
              rx_state <= RX_IDLE;
            end else begin
              rx_tcnt <= rx_tcnt + 4'd1;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // A good stop bit commits the byte; a framing error simply drops it.
  assign rx_load = (rx_state == RX_STOP) && tick && (rx_tcnt == TICKS_LAST) && rx_sync;

  // New byte wins over a same-cycle read, so rda never drops on a fresh byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf <= '0;
      rda    <= 1'b0;
    end else if (rx_load) begin
      rx_buf <= rx_sr;
      rda    <= 1'b1;
    end else if (req.rd && req.addr == ADDR_RX) begin
      rda    <= 1'b0;
    end
  end

  // ---------------- read path ----------------

  // Read data is a pure function of the address.
  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      ADDR_RX: rd_data = rx_buf;
      ADDR_TX: rd_data = status_byte(tbr, rda);
      default: rd_data = 8'h00;
    endcase
  end

  assign databus = req.rd ? rd_data : 8'hzz;

endmodule
